eth_preamble_hdr_parser: RTL
============================

// Module: eth_preamble_hdr_parser
// PURPOSE
//  Multi-byte AXI-Stream front end for the packet parser. Validates and strips the 8-byte
//  preamble/SFD, forwards the frame from DA onward, and extracts DA/SA/EtherType (VLAN-aware).
//  Flags bad-preamble and runt frames and keeps saturating frame counters. Sits between MAC RX and L3 parsers.
// PARAMETERS
//  DATA_W  8   stream width in bits; 8*BYTES, BYTES in {1,2,4,8}
//  CNT_W   32  width of each statistics counter
// PORTS
//  aclk            in   1          clock; all logic on rising edge
//  aresetn         in   1          synchronous active-low reset
//  s_axis_tdata    in   DATA_W     input bytes; lane 0 = earliest byte on the wire
//  s_axis_tkeep    in   DATA_W/8   byte enables; only the tlast beat may be partial
//  s_axis_tvalid   in   1          input valid
//  s_axis_tlast    in   1          last beat of frame
//  s_axis_tready   out  1          input ready
//  m_axis_tdata    out  DATA_W     frame bytes, DA first, preamble/SFD removed
//  m_axis_tkeep    out  DATA_W/8   byte enables
//  m_axis_tvalid   out  1          output valid
//  m_axis_tlast    out  1          last beat
//  m_axis_tuser    out  1          on tlast beat: 1 = runt (header incomplete)
//  m_axis_tready   in   1          output ready
//  meta_valid      out  1          1-cycle pulse: header fields valid
//  meta_dst_mac    out  48         DA, byte 0 in [47:40]
//  meta_src_mac    out  48         SA, byte 6 in [47:40]
//  meta_ethertype  out  16         inner EtherType (after VLAN tag if present)
//  meta_vlan_valid out  1          802.1Q tag present
//  meta_vlan_id    out  12         VID, 0 if no tag
//  meta_is_ipv4    out  1          ethertype == 0x0800
//  meta_is_ipv6    out  1          ethertype == 0x86DD
//  stat_frames_ok  out  CNT_W      frames forwarded with complete header
//  stat_bad_pre    out  CNT_W      frames dropped for preamble/SFD mismatch
//  stat_runt       out  CNT_W      frames ending before header complete
// BEHAVIOUR
//  - Reset: all outputs 0, state S_IDLE, counters 0. Reset mid-frame discards the frame; no partial output.
//  - Wire order: 7x 0x55, then 0xD5, beat-aligned. PRE_BEATS = 8/BYTES. Preamble beats need full tkeep.
//  - Handshake: beat accepted when s_tvalid && s_tready. Output is a single register stage.
//    In S_FWD, s_tready = !m_tvalid || m_tready. In S_IDLE/S_PRE/S_DROP, s_tready = 1.
//    Latency is 1 cycle input->output. m_axis signals stay stable while m_tvalid && !m_tready.
//  - FSM:
//    S_IDLE: accepted beat is preamble beat 0. Match, PRE_BEATS==1 -> S_FWD. Match, else -> S_PRE, pre_cnt=1.
//      Mismatch -> S_DROP.
//    S_PRE: compare beat pre_cnt. Match on last preamble beat -> S_FWD. Match otherwise -> pre_cnt++.
//      Mismatch -> S_DROP.
//    Any preamble beat with tlast: stat_bad_pre++, -> S_IDLE. S_DROP then exits via tlast, which also counts.
//    S_DROP: sink beats; on tlast stat_bad_pre++, -> S_IDLE.
//    S_FWD: forward beats. byte_cnt (5b, saturates at 18) += popcount(tkeep).
//      Capture bytes 0..17 by absolute index. On tlast -> S_IDLE.
//  - Header complete: byte_cnt reaches 14 with bytes[12:13] != 0x8100, or reaches 18 with a tag.
//    With a tag: vlan_id = bytes[14:15] & 0xFFF, ethertype = bytes[16:17].
//    meta_valid pulses the cycle after the completing beat is accepted. Fields hold until the next pulse.
//  - Runt (tlast before complete): m_tuser=1 on tlast beat, no meta_valid, stat_runt++.
//    Otherwise stat_frames_ok++ on tlast.
//  - Simultaneous: completion and tlast in one beat gives meta_valid, frames_ok++, tuser=0.
//  - Counters saturate at all-ones, no wrap. New frame in S_IDLE may follow tlast with no gap.
// STRUCTURE
//  - eth_pkg: PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, ETH_TYPE_IPV4/IPV6/VLAN constants,
//    PREAMBLE_WORD=64'hD555_5555_5555_5555, typedef enum {S_IDLE,S_PRE,S_FWD,S_DROP} pre_state_t.
//  - One sub-module: eth_hdr_capture (byte_cnt, 18-byte capture, completion/meta logic). FSM and output register stay top-level.
// TESTING
//  - DATA_W=8: 55x7,D5, DA=01..06, SA=0A..0F, type 0800, 46B payload -> meta pulse, is_ipv4=1, 60B out.
//  - DATA_W=64: beat0=PREAMBLE_WORD, DA..type 86DD -> out starts at DA, 1-cycle latency, is_ipv6=1.
//  - DATA_W=32: tag 8100 VID 0x123, inner 0800 -> vlan_valid=1, vlan_id=0x123, meta after byte 17.
//  - Byte 3 of preamble = 0x54 -> whole frame dropped, no m_tvalid, stat_bad_pre=1.
//  - Frame tlast at byte 10 after SFD -> 10B forwarded, tuser=1 on last, stat_runt=1, no meta.
//  - m_tready toggled 50%, back-to-back frames -> data/order intact, stable under stall, frames_ok=N.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared constants, state type and helpers for the Ethernet preamble/header front end.
package eth_pkg;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   // Wire order is lane 0 first, so the SFD lands in the top byte of the word.
   localparam logic [63:0] PREAMBLE_WORD = {SFD_BYTE, {7{PREAMBLE_BYTE}}};

   localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
   localparam logic [15:0] ETH_TYPE_IPV6 = 16'h86DD;
   localparam logic [15:0] ETH_TYPE_VLAN = 16'h8100;

   localparam int PREAMBLE_LEN     = 8;   // preamble + SFD bytes
   localparam int HDR_LEN_UNTAGGED = 14;  // DA + SA + EtherType
   localparam int HDR_BYTES        = 18;  // DA + SA + 802.1Q tag + EtherType

   typedef enum logic [1:0] {
      S_IDLE,
      S_PRE,
      S_FWD,
      S_DROP
   } pre_state_t;

   // Header byte counter update; parks at HDR_BYTES so it never wraps on long frames.
   function automatic logic [4:0] hdr_cnt_add(input logic [4:0] cnt, input logic [3:0] add);
      logic [5:0] sum;
      sum = {1'b0, cnt} + {2'b00, add};
      return (sum > 6'(HDR_BYTES)) ? 5'(HDR_BYTES) : sum[4:0];
   endfunction

endpackage

// File: rtl/eth_hdr_capture.sv
// Tracks byte position within a forwarded frame, captures the first 18 bytes
// and publishes DA/SA/EtherType/VLAN metadata once the header is complete.
module eth_hdr_capture #(
   parameter int DATA_W = 8
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic                beat_en,
   input  logic [DATA_W-1:0]   tdata,
   input  logic [DATA_W/8-1:0] tkeep,
   input  logic                tlast,
   output logic                hdr_ok,
   output logic                meta_valid,
   output logic [47:0]         meta_dst_mac,
   output logic [47:0]         meta_src_mac,
   output logic [15:0]         meta_ethertype,
   output logic                meta_vlan_valid,
   output logic [11:0]         meta_vlan_id,
   output logic                meta_is_ipv4,
   output logic                meta_is_ipv6
);
   import eth_pkg::*;

   localparam int BYTES = DATA_W / 8;

   logic [4:0]  byte_cnt_q;
   logic [4:0]  byte_cnt_d;
   logic        done_q;
   logic [3:0]  beat_bytes;
   logic [7:0]  hdr_q [HDR_BYTES];
   logic [7:0]  hdr_d [HDR_BYTES];
   logic        is_vlan;
   logic        complete_now;
   logic [15:0] ethertype_d;
   logic [11:0] vlan_id_d;

   // Count the enabled lanes of the current beat.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      beat_bytes = '0;
      for (int l = 0; l < BYTES; l++) begin
         beat_bytes = beat_bytes + 4'(tkeep[l]);
      end
   end

   // Merge the current beat into the header image by absolute byte index.
   always_comb begin
      for (int i = 0; i < HDR_BYTES; i++) begin
         hdr_d[i] = hdr_q[i];
         for (int l = 0; l < BYTES; l++) begin
            if (tkeep[l] && (int'(byte_cnt_q) + l == i)) begin
               hdr_d[i] = tdata[l*8 +: 8];
            end
         end
      end
   end

   // Decide whether this beat completes the header and derive the tag-aware fields.
   always_comb begin
      byte_cnt_d   = hdr_cnt_add(byte_cnt_q, beat_bytes);
      is_vlan      = ({hdr_d[12], hdr_d[13]} == ETH_TYPE_VLAN);
      complete_now = beat_en && !done_q &&
                     (is_vlan ? (byte_cnt_d >= 5'(HDR_BYTES))
                              : (byte_cnt_d >= 5'(HDR_LEN_UNTAGGED)));
      hdr_ok       = done_q || complete_now;
      ethertype_d  = is_vlan ? {hdr_d[16], hdr_d[17]} : {hdr_d[12], hdr_d[13]};
      vlan_id_d    = is_vlan ? {hdr_d[14][3:0], hdr_d[15]} : 12'h000;
   end

   // Byte position and header-done flag; both restart after the last beat.
   always_ff @(posedge aclk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!aresetn) begin
         byte_cnt_q <= '0;
         done_q     <= 1'b0;
      end else if (beat_en) begin
         if (tlast) begin
            byte_cnt_q <= '0;
            done_q     <= 1'b0;
         end else begin
            byte_cnt_q <= byte_cnt_d;
            done_q     <= done_q || complete_now;
         end
      end
   end

   // Header byte storage.
   always_ff @(posedge aclk) begin
      // NOTE: storage array has no reset; bytes are only read once byte_cnt proves them written.
      if (beat_en) begin
         hdr_q <= hdr_d;
      end
   end

   // Metadata register: one-cycle pulse, fields hold until the next completion.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         meta_valid      <= 1'b0;
         meta_dst_mac    <= '0;
         meta_src_mac    <= '0;
         meta_ethertype  <= '0;
         meta_vlan_valid <= 1'b0;
         meta_vlan_id    <= '0;
         meta_is_ipv4    <= 1'b0;
         meta_is_ipv6    <= 1'b0;
      end else begin
         meta_valid <= complete_now;
         if (complete_now) begin
            meta_dst_mac    <= {hdr_d[0], hdr_d[1], hdr_d[2], hdr_d[3], hdr_d[4], hdr_d[5]};
            meta_src_mac    <= {hdr_d[6], hdr_d[7], hdr_d[8], hdr_d[9], hdr_d[10], hdr_d[11]};
            meta_ethertype  <= ethertype_d;
            meta_vlan_valid <= is_vlan;
            meta_vlan_id    <= vlan_id_d;
            meta_is_ipv4    <= (ethertype_d == ETH_TYPE_IPV4);
            meta_is_ipv6    <= (ethertype_d == ETH_TYPE_IPV6);
         end
      end
   end

endmodule

// File: rtl/eth_preamble_hdr_parser.sv
// AXI-Stream MAC RX front end: checks and strips preamble/SFD, forwards the frame
// from DA onward through one register stage, extracts header metadata, keeps stats.
module eth_preamble_hdr_parser #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 32
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic [DATA_W-1:0]   s_axis_tdata,
   input  logic [DATA_W/8-1:0] s_axis_tkeep,
   input  logic                s_axis_tvalid,
   input  logic                s_axis_tlast,
   output logic                s_axis_tready,
   output logic [DATA_W-1:0]   m_axis_tdata,
   output logic [DATA_W/8-1:0] m_axis_tkeep,
   output logic                m_axis_tvalid,
   output logic                m_axis_tlast,
   output logic                m_axis_tuser,
   input  logic                m_axis_tready,
   output logic                meta_valid,
   output logic [47:0]         meta_dst_mac,
   output logic [47:0]         meta_src_mac,
   output logic [15:0]         meta_ethertype,
   output logic                meta_vlan_valid,
   output logic [11:0]         meta_vlan_id,
   output logic                meta_is_ipv4,
   output logic                meta_is_ipv6,
   output logic [CNT_W-1:0]    stat_frames_ok,
   output logic [CNT_W-1:0]    stat_bad_pre,
   output logic [CNT_W-1:0]    stat_runt
);
   import eth_pkg::*;

   localparam int BYTES     = DATA_W / 8;
   localparam int PRE_BEATS = PREAMBLE_LEN / BYTES;

   pre_state_t        state_q;
   pre_state_t        state_d;
   logic [2:0]        pre_cnt_q;
   logic [2:0]        pre_cnt_d;
   logic [2:0]        pre_idx;
   logic [DATA_W-1:0] pre_exp;
   logic              pre_match;
   logic              pre_last;
   logic              accept;
   logic              fwd_en;
   logic              bad_pre_inc;
   logic              hdr_ok;

   // Preamble phases always sink; forwarding is throttled by the output register.
   assign s_axis_tready = (state_q == S_FWD) ? (!m_axis_tvalid || m_axis_tready) : 1'b1;
   assign accept        = s_axis_tvalid && s_axis_tready;

   // Select the expected preamble slice for the current beat and compare.
   always_comb begin
      pre_idx = (state_q == S_PRE) ? pre_cnt_q : 3'd0;
      pre_exp = '0;
      for (int k = 0; k < PRE_BEATS; k++) begin
         if (pre_idx == 3'(k)) pre_exp = PREAMBLE_WORD[k*DATA_W +: DATA_W];
      end
      pre_match = (s_axis_tdata == pre_exp) && (&s_axis_tkeep);
      pre_last  = (pre_idx == 3'(PRE_BEATS - 1));
   end

   // Next-state and per-beat strobes.
   always_comb begin
      state_d     = state_q;
      pre_cnt_d   = pre_cnt_q;
      fwd_en      = 1'b0;
      bad_pre_inc = 1'b0;
      case (state_q)
         S_IDLE, S_PRE: begin
            if (accept) begin
               if (s_axis_tlast) begin
                  bad_pre_inc = 1'b1;
                  state_d     = S_IDLE;
                  pre_cnt_d   = '0;
               end else if (!pre_match) begin
                  state_d = S_DROP;
               end else if (pre_last) begin
                  state_d = S_FWD;
               end else begin
                  state_d   = S_PRE;
                  pre_cnt_d = pre_idx + 3'd1;
               end
            end
         end
         S_DROP: begin
            if (accept && s_axis_tlast) begin
               bad_pre_inc = 1'b1;
               state_d     = S_IDLE;
            end
         end
         S_FWD: begin
            if (accept) begin
               fwd_en = 1'b1;
               if (s_axis_tlast) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q   <= S_IDLE;
         pre_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         pre_cnt_q <= pre_cnt_d;
      end
   end

   // Single output register stage; holds its contents while stalled.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= 1'b0;
      end else if (fwd_en) begin
         m_axis_tvalid <= 1'b1;
         m_axis_tdata  <= s_axis_tdata;
         m_axis_tkeep  <= s_axis_tkeep;
         m_axis_tlast  <= s_axis_tlast;
         m_axis_tuser  <= s_axis_tlast && !hdr_ok;
      end else if (m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
      end
   end

   // Saturating frame statistics.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         stat_frames_ok <= '0;
         stat_bad_pre   <= '0;
         stat_runt      <= '0;
      end else begin
         if (fwd_en && s_axis_tlast && hdr_ok && (stat_frames_ok != '1))
            stat_frames_ok <= stat_frames_ok + CNT_W'(1);
         if (fwd_en && s_axis_tlast && !hdr_ok && (stat_runt != '1))
            stat_runt <= stat_runt + CNT_W'(1);
         if (bad_pre_inc && (stat_bad_pre != '1))
            stat_bad_pre <= stat_bad_pre + CNT_W'(1);
      end
   end

   eth_hdr_capture #(
      .DATA_W (DATA_W)
   ) u_hdr_capture (
      .aclk            (aclk),
      .aresetn         (aresetn),
      .beat_en         (fwd_en),
      .tdata           (s_axis_tdata),
      .tkeep           (s_axis_tkeep),
      .tlast           (s_axis_tlast),
      .hdr_ok          (hdr_ok),
      .meta_valid      (meta_valid),
      .meta_dst_mac    (meta_dst_mac),
      .meta_src_mac    (meta_src_mac),
      .meta_ethertype  (meta_ethertype),
      .meta_vlan_valid (meta_vlan_valid),
      .meta_vlan_id    (meta_vlan_id),
      .meta_is_ipv4    (meta_is_ipv4),
      .meta_is_ipv6    (meta_is_ipv6)
   );

endmodule
